serial_comparator: RTL and testbench

- Bit-serial, MSB-first magnitude comparator for two N-bit operands.
- Per-request mode selects signed (two's complement) or unsigned comparison.
- Replaces a wide parallel subtract/OR-tree compare with a small shift/counter datapath in area-constrained paths.
- Uses a start/busy/done handshake; the lt/eq/gt result is registered and held.

---
 rtl/serial_comparator.sv | 115 +++++++++++
 tb/tb_serial_comparator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator (signed/unsigned per request) with start/busy/done handshake.
// Optional SERIAL_COMPARATOR_EARLY_EXIT_EN: finish on the first differing bit instead of after all N bits.
module serial_comparator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         start,
    input  logic         isSigned,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]    state_reg;
    logic [N-1:0]  x_reg;
    logic [N-1:0]  y_reg;
    logic          signed_reg;
    logic [CW-1:0] count_reg;
    logic          decided_reg;
    logic          gt_found_reg;
    logic          lt_reg;
    logic          eq_reg;
    logic          gt_reg;

    logic x_bit;
    logic y_bit;
    logic differ;
    logic at_msb;
    logic bit_gt;
    logic final_decided;
    logic final_gt;
    logic finish;
    logic load;

    always_comb begin
        x_bit  = x_reg[count_reg];
        y_bit  = y_reg[count_reg];
        differ = x_bit ^ y_bit;
        at_msb = (count_reg == CW'(N - 1));
        // A set sign bit makes x the smaller operand in two's complement.
        bit_gt = (at_msb && signed_reg) ? ~x_bit : x_bit;
        final_decided = decided_reg | differ;
        final_gt      = decided_reg ? gt_found_reg : bit_gt;
        load          = start && (state_reg != COMPARE);
    end

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    assign finish = (count_reg == '0) || (!decided_reg && differ);
`else
    assign finish = (count_reg == '0);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            signed_reg   <= 1'b0;
            count_reg    <= '0;
            decided_reg  <= 1'b0;
            gt_found_reg <= 1'b0;
            lt_reg       <= 1'b0;
            eq_reg       <= 1'b0;
            gt_reg       <= 1'b0;
        end else begin
            if (load) begin
                x_reg       <= x;
                y_reg       <= y;
                signed_reg  <= isSigned;
                count_reg   <= CW'(N - 1);
                decided_reg <= 1'b0;
            end
            case (state_reg)
                IDLE, DONE: begin
                    state_reg <= load ? COMPARE : IDLE;
                end
                COMPARE: begin
                    if (!decided_reg && differ) begin
                        decided_reg  <= 1'b1;
                        gt_found_reg <= bit_gt;
                    end
                    if (finish) begin
                        state_reg <= DONE;
                        lt_reg    <= final_decided & ~final_gt;
                        gt_reg    <= final_decided & final_gt;
                        eq_reg    <= ~final_decided;
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == COMPARE);
    assign done = (state_reg == DONE);
    assign lt   = lt_reg;
    assign eq   = eq_reg;
    assign gt   = gt_reg;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator (N=8): directed cases plus random operands vs. an arithmetic model.
module tb_serial_comparator;

    localparam int N = 8;

    logic         clk;
    logic         resetN;
    logic         start;
    logic         isSigned;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic         gt;

    int vectors    = 0;
    int miscompares = 0;

    serial_comparator #(.N(N)) dut (
        .clk(clk), .resetN(resetN), .start(start), .isSigned(isSigned),
        .x(x), .y(y), .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {lt,eq,gt} from plain integer comparison.
    function automatic logic [2:0] model_res(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        int ia;
        int ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        if (ia < ib) return 3'b100;
        if (ia > ib) return 3'b001;
        return 3'b010;
    endfunction

    // Edges from the start edge until done is visible.
    function automatic int model_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (a[k] != b[k]) return N - k;
        end
`endif
        return N + 0 * int'(a ^ b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then scramble the inputs.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        @(negedge clk);
        start = 1'b1; x = a; y = b; isSigned = s;
        @(negedge clk);
        start = 1'b0;
        x = N'($urandom); y = N'($urandom); isSigned = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run_cmp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        int lat;
        launch(a, b, s);
        wait_done(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(model_lat(a, b)));
        check({tag, "_res"}, 32'({lt, eq, gt}), 32'(model_res(a, b, s)));
        @(negedge clk);
        check({tag, "_pulse"}, 32'({busy, done}), 32'b00);
        $display("cmp %s x=%02h y=%02h signed=%0d lat=%0d res=%03b", tag, a, b, s, lat, {lt, eq, gt});
    endtask

    initial begin
        int lat;
        int gap;
        int extra;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;

        resetN = 1'b0; start = 1'b0; isSigned = 1'b0; x = '0; y = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_out", 32'({busy, done, lt, eq, gt}), 32'b0);
        resetN = 1'b1;

        // Busy must stay high for the whole unsigned 0x80/0x7F compare.
        launch(8'h80, 8'h7F, 1'b0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) check("busy_hold", 32'(busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        check("u80_7f_lat", 32'(lat), 32'(model_lat(8'h80, 8'h7F)));
        check("u80_7f_res", 32'({lt, eq, gt}), 32'b001);
        check("u80_7f_busy", 32'(busy), 32'd0);
        $display("cmp u80_7f lat=%0d res=%03b", lat, {lt, eq, gt});
        @(negedge clk);

        run_cmp("s80_7f", 8'h80, 8'h7F, 1'b1);
        check("s80_7f_const", 32'({lt, eq, gt}), 32'b100);
        run_cmp("sff_fe", 8'hFF, 8'hFE, 1'b1);
        check("sff_fe_const", 32'({lt, eq, gt}), 32'b001);
        run_cmp("u55_55", 8'h55, 8'h55, 1'b0);
        run_cmp("s55_55", 8'h55, 8'h55, 1'b1);
        check("s55_const", 32'({lt, eq, gt}), 32'b010);

        // Start pulsed mid-compare must be ignored.
        launch(8'h55, 8'h54, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; x = 8'h00; y = 8'hFF; isSigned = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_lat", 32'(lat), 32'd8);
        check("ignore_res", 32'({lt, eq, gt}), 32'b001);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("ignore_once", 32'(extra), 32'd0);
        $display("cmp ignore lat=%0d extra_done=%0d", lat, extra);

        // Back-to-back: start held through DONE with a second operand pair.
        @(negedge clk);
        start = 1'b1; x = 8'h80; y = 8'h7F; isSigned = 1'b0;
        @(negedge clk);
        x = 8'h10; y = 8'h20;
        wait_done("b2b_first", lat);
        check("b2b_first_res", 32'({lt, eq, gt}), 32'b001);
        @(negedge clk);
        start = 1'b0;
        x = 8'hAA; y = 8'hAA;
        check("b2b_nobubble", 32'({busy, done}), 32'b10);
        check("b2b_held", 32'({lt, eq, gt}), 32'b001);
        gap = 1;
        while (done !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'(1 + model_lat(8'h10, 8'h20)));
        check("b2b_second_res", 32'({lt, eq, gt}), 32'b100);
        $display("cmp b2b gap=%0d res=%03b", gap, {lt, eq, gt});
        @(negedge clk);

        // Asynchronous reset mid-compare.
        launch(8'h01, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 resetN = 1'b0;
        #1 check("areset_out", 32'({busy, done, lt, eq, gt}), 32'b0);
        @(negedge clk);
        resetN = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("areset_nodone", 32'(extra), 32'd0);
        $display("cmp areset extra_done=%0d", extra);
        run_cmp("post_reset", 8'h01, 8'h00, 1'b0);

        // Latency boundaries for early exit.
        run_cmp("u80_00", 8'h80, 8'h00, 1'b0);
        run_cmp("u01_00", 8'h01, 8'h00, 1'b0);
        run_cmp("s7f_80", 8'h7F, 8'h80, 1'b1);
        run_cmp("u00_ff", 8'h00, 8'hFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : N'($urandom);
            rs = 1'($urandom);
            run_cmp($sformatf("rnd%0d", i), ra, rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
